// File: rtl/accum_frame_array_if.sv
// Sample-in / frame-result-out handshake bundle for accum_frame_array.
// master = producer/consumer side, slave = the accumulator block.
interface accum_frame_array_if #(
    parameter int IN_W     = 8,
    parameter int ACC_W    = 16,
    parameter int CHANNELS = 4
) ();
    localparam int CH_W = $clog2(CHANNELS);

    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch;
    logic             in_sub;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_ch, in_sub, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_ch, in_sub, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_ovf
    );
endinterface

// File: rtl/accum_frame_array.sv
// Multi-channel add/subtract frame accumulator: emits one sum per channel every FRAME_LEN samples.
// Define ACCUM_FRAME_SAT_EN to clamp on overflow/underflow instead of wrapping.
module accum_frame_array #(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 16,
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    accum_frame_array_if.slave  bus
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [ACC_W-1:0]    acc_reg [CHANNELS];
    logic [CNT_W-1:0]    cnt_reg [CHANNELS];
    logic [CHANNELS-1:0] ovf_reg;

    logic                out_valid_reg;
    logic [CH_W-1:0]     out_ch_reg;
    logic [ACC_W-1:0]    out_data_reg;
    logic                out_ovf_reg;

    logic                ch_ok;
    logic [CH_W-1:0]     ch_idx;
    logic                accept;
    logic                hit;
    logic                frame_done;
    logic [ACC_W:0]      operand;
    logic [ACC_W:0]      sum_ext;
    logic                carry;
    logic [ACC_W-1:0]    acc_next;
    logic [CHANNELS-1:0] ch_hit;

    // Out-of-range channel numbers only exist when CHANNELS is not a power of two.
    generate
        if (CHANNELS == (1 << CH_W)) begin : g_full_range
            assign ch_ok = 1'b1;
        end else begin : g_part_range
            assign ch_ok = (int'(bus.in_ch) < CHANNELS);
        end
    endgenerate

    assign ch_idx       = ch_ok ? bus.in_ch : '0;
    assign bus.in_ready = !rst && !clr && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign hit          = accept && ch_ok;
    assign frame_done   = hit && (cnt_reg[ch_idx] == CNT_LAST);

    // One extra bit catches both the add carry and the subtract borrow.
    assign operand = {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};
    assign sum_ext = bus.in_sub ? ({1'b0, acc_reg[ch_idx]} - operand)
                                : ({1'b0, acc_reg[ch_idx]} + operand);
    assign carry   = sum_ext[ACC_W];

    always_comb begin
        acc_next = sum_ext[ACC_W-1:0];
`ifdef ACCUM_FRAME_SAT_EN
        if (carry) begin
            acc_next = bus.in_sub ? '0 : '1;
        end
`endif
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign ch_hit[gi] = hit && (ch_idx == CH_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_reg[i] <= '0;
                cnt_reg[i] <= '0;
            end
            ovf_reg <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_hit[i]) begin
                    if (frame_done) begin
                        acc_reg[i] <= '0;
                        cnt_reg[i] <= '0;
                        ovf_reg[i] <= 1'b0;
                    end else begin
                        acc_reg[i] <= acc_next;
                        cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
                        ovf_reg[i] <= ovf_reg[i] | carry;
                    end
                end
            end
        end
    end

    // A completing frame can only be accepted when the slot is free or being drained,
    // so loading here never overwrites an unconsumed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            out_data_reg  <= '0;
            out_ovf_reg   <= 1'b0;
        end else if (frame_done) begin
            out_valid_reg <= 1'b1;
            out_ch_reg    <= bus.in_ch;
            out_data_reg  <= acc_next;
            out_ovf_reg   <= ovf_reg[ch_idx] | carry;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_ovf   = out_ovf_reg;
endmodule
